weight_writeback_bank: RTL

- Consumer of the training block's per-weight output; sits directly downstream of it.
- Accepts the stream of updated weights (one per valid cycle) into a current-weights bank. That bank also feeds back the old weight for the next pass.
- Tracks pass boundaries and latches the "best weights" flag raised during a pass.
- At the end of such a pass, copies the whole current bank into a best-weights bank, so the roots at the least error are retained after training completes.

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_ram.sv | 34 +++
 rtl/weight_writeback_bank.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for weight_writeback_bank and its storage banks.
package wb_pkg;

    localparam int unsigned WEIGHT_W = 34;

    localparam logic [WEIGHT_W-1:0] WEIGHT_ZERO = '0;

    typedef enum logic [1:0] {
        StAccept,
        StCopy,
        StDone
    } wb_state_e;

    // A pass needs at least two weights and every weight must be addressable.
    function automatic bit addr_width_ok(input int unsigned n, input int unsigned aw);
        return (n >= 2) && ((64'(1) << aw) >= 64'(n));
    endfunction

endpackage

// File: rtl/wb_ram.sv
// Simple dual-port bank: one write port, one registered read port, array not reset.
module wb_ram
    import wb_pkg::*;
#(
    parameter int unsigned DW    = WEIGHT_W,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= DW'(WEIGHT_ZERO);
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/weight_writeback_bank.sv
// Current/best weight banks with pass tracking and best-snapshot copy.
// Optional macro WB_RD_FORWARD_EN makes the rd_weight port write-first.
module weight_writeback_bank
    import wb_pkg::*;
#(
    parameter  int unsigned BIT_WIDTH      = 32,
    parameter  int unsigned EXTRA_BIT      = 2,
    parameter  int unsigned NUMBER_WEIGHTS = 16,
    parameter  int unsigned ADDR_WIDTH     = 4,
    localparam int unsigned W              = BIT_WIDTH + EXTRA_BIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    input  logic [W-1:0]          wr_weight,
    input  logic                  best_flag,
    input  logic                  training_done,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [W-1:0]          rd_weight,
    input  logic [ADDR_WIDTH-1:0] best_rd_addr,
    output logic [W-1:0]          best_weight,
    output logic                  pass_done,
    output logic                  busy,
    output logic                  best_valid,
    output logic                  frozen,
    output logic                  overrun
);

    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUMBER_WEIGHTS - 1);
    localparam logic [CW-1:0] COPY_LAST = CW'(NUMBER_WEIGHTS);

    if (!addr_width_ok(NUMBER_WEIGHTS, ADDR_WIDTH)) begin : g_cfg_err
        $error("weight_writeback_bank: ADDR_WIDTH too small or NUMBER_WEIGHTS < 2");
    end

    wb_state_e             state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                  best_pending;
    logic [CW-1:0]         copy_cnt;

    logic                  cur_we;
    logic                  pass_end;
    logic                  take;
    logic                  best_we;
    logic [ADDR_WIDTH-1:0] cur_raddr;
    logic [ADDR_WIDTH-1:0] copy_waddr;
    logic [W-1:0]          cur_rdata;

    // The copy borrows the current bank's read port; best[i] is written one cycle after cur[i] is read.
    always_comb begin
        cur_we     = (state == StAccept) && wr_valid;
        pass_end   = cur_we && (wr_ptr == LAST_ADDR);
        take       = best_pending | best_flag;
        cur_raddr  = (state == StCopy) ? copy_cnt[ADDR_WIDTH-1:0] : rd_addr;
        best_we    = (state == StCopy) && (copy_cnt != '0);
        copy_waddr = copy_cnt[ADDR_WIDTH-1:0] - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= StAccept;
            wr_ptr       <= '0;
            best_pending <= 1'b0;
            copy_cnt     <= '0;
            pass_done    <= 1'b0;
            busy         <= 1'b0;
            best_valid   <= 1'b0;
            frozen       <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            pass_done <= 1'b0;
            unique case (state)
                StAccept: begin
                    if (cur_we) begin
                        wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
                    end
                    if (pass_end) begin
                        pass_done    <= 1'b1;
                        best_pending <= 1'b0;
                        if (take) begin
                            state    <= StCopy;
                            busy     <= 1'b1;
                            copy_cnt <= '0;
                        end
                    end else begin
                        best_pending <= take;
                        // A mid-pass training_done waits here until the pass wraps.
                        if (training_done && (wr_ptr == '0) && !wr_valid) begin
                            state  <= StDone;
                            frozen <= 1'b1;
                        end
                    end
                end
                StCopy: begin
                    best_pending <= take;
                    if (wr_valid) begin
                        overrun <= 1'b1;
                    end
                    if (copy_cnt == COPY_LAST) begin
                        busy       <= 1'b0;
                        best_valid <= 1'b1;
                        copy_cnt   <= '0;
                        state      <= training_done ? StDone : StAccept;
                        frozen     <= training_done;
                    end else begin
                        copy_cnt <= copy_cnt + 1'b1;
                    end
                end
                StDone: begin
                    state <= StDone;
                end
                default: begin
                    state <= StAccept;
                end
            endcase
        end
    end

    wb_ram #(
        .DW    (W),
        .DEPTH (NUMBER_WEIGHTS),
        .AW    (ADDR_WIDTH)
    ) u_cur (
        .clk   (clk),
        .rst   (rst),
        .we    (cur_we),
        .waddr (wr_ptr),
        .wdata (wr_weight),
        .raddr (cur_raddr),
        .rdata (cur_rdata)
    );

    wb_ram #(
        .DW    (W),
        .DEPTH (NUMBER_WEIGHTS),
        .AW    (ADDR_WIDTH)
    ) u_best (
        .clk   (clk),
        .rst   (rst),
        .we    (best_we),
        .waddr (copy_waddr),
        .wdata (cur_rdata),
        .raddr (best_rd_addr),
        .rdata (best_weight)
    );

`ifdef WB_RD_FORWARD_EN
    logic         fwd_sel;
    logic [W-1:0] fwd_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_sel  <= 1'b0;
            fwd_data <= W'(WEIGHT_ZERO);
        end else begin
            fwd_sel  <= cur_we && (rd_addr == wr_ptr);
            fwd_data <= wr_weight;
        end
    end

    assign rd_weight = fwd_sel ? fwd_data : cur_rdata;
`else
    assign rd_weight = cur_rdata;
`endif

endmodule
